// File: rtl/asynchronous_fifo_write_controller_pkg.sv
// Shared definitions for the asynchronous FIFO controllers: Gray/binary pointer
// conversion helpers sized for any pointer up to 32 bits wide.
package asynchronous_fifo_write_controller_pkg;

  localparam int POINTER_WORD_WIDTH = 32;

  typedef logic [POINTER_WORD_WIDTH-1:0] pointer_word_t;

  // Zero-extended inputs convert correctly, so callers cast their pointers in and out.
  function automatic pointer_word_t binary_to_gray(input pointer_word_t binary);
    return binary ^ (binary >> 1);
  endfunction

  // Prefix XOR from the MSB down, computed with log2 doubling steps.
  function automatic pointer_word_t gray_to_binary(input pointer_word_t gray);
    pointer_word_t binary;
    binary = gray;
    for (int shift = 1; shift < POINTER_WORD_WIDTH; shift = shift * 2) begin
      binary = binary ^ (binary >> shift);
    end
    return binary;
  endfunction

endpackage

// File: rtl/asynchronous_fifo_write_controller_vector_synchronizer.sv
// Multi-flop synchronizer for a vector whose value changes by at most one bit at
// a time (a Gray pointer); reused by both FIFO controllers.
module vector_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] async_value,
  output logic [WIDTH-1:0] sync_value
);

  logic [WIDTH-1:0] chain [STAGES];

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("vector_synchronizer needs at least two stages");
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= async_value;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign sync_value = chain[STAGES-1];

endmodule

// File: rtl/asynchronous_fifo_write_controller.sv
// Write-side controller of the dual-clock FIFO: drives the RAM write port,
// publishes a registered Gray write pointer and derives full/level/overflow.
module asynchronous_fifo_write_controller
  import asynchronous_fifo_write_controller_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int STAGES        = 2
) (
  input  logic                     write_clock,
  input  logic                     write_resetn,
  input  logic                     write_valid,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     write_ready,
  output logic                     full,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_write_address,
  output logic [WIDTH-1:0]         memory_write_data,
  output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  input  logic [ADDRESS_WIDTH:0]   read_pointer_gray
);

  localparam int POINTER_WIDTH = ADDRESS_WIDTH + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
    end
    if ((1 << ADDRESS_WIDTH) != DEPTH) begin : g_bad_address_width
      $error("ADDRESS_WIDTH must equal clog2(DEPTH)");
    end
    if (POINTER_WIDTH > POINTER_WORD_WIDTH) begin : g_bad_pointer_width
      $error("pointer wider than the conversion helpers support");
    end
  endgenerate

  logic [POINTER_WIDTH-1:0] write_pointer;
  logic [POINTER_WIDTH-1:0] write_pointer_next;
  logic [POINTER_WIDTH-1:0] gray_next;
  logic [POINTER_WIDTH-1:0] read_pointer_sync_gray;
  logic [POINTER_WIDTH-1:0] read_pointer_sync;
  logic                     transfer;

  vector_synchronizer #(
    .WIDTH  (POINTER_WIDTH),
    .STAGES (STAGES)
  ) u_read_pointer_sync (
    .clock       (write_clock),
    .resetn      (write_resetn),
    .async_value (read_pointer_gray),
    .sync_value  (read_pointer_sync_gray)
  );

  // The synchronized pointer only ever lags the real one, so level errs high
  // and full releases late, never early.
  assign read_pointer_sync = POINTER_WIDTH'(gray_to_binary(pointer_word_t'(read_pointer_sync_gray)));
  assign level             = write_pointer - read_pointer_sync;
  assign full              = (level == POINTER_WIDTH'(DEPTH));

  assign write_ready = write_resetn && !full;
  assign transfer    = write_valid && write_ready;

  // NOTE: every combinational signal gets a default before any condition so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    write_pointer_next = write_pointer;
    if (transfer) write_pointer_next = write_pointer + 1'b1;
  end

  assign gray_next = POINTER_WIDTH'(binary_to_gray(pointer_word_t'(write_pointer_next)));

  // The Gray pointer is loaded from the next-state value so it is glitch-free
  // at the domain crossing and tracks write_pointer with no extra cycle.
  always_ff @(posedge write_clock or negedge write_resetn) begin
    if (!write_resetn) begin
      write_pointer      <= '0;
      write_pointer_gray <= '0;
      overflow           <= 1'b0;
    end else begin
      write_pointer      <= write_pointer_next;
      write_pointer_gray <= gray_next;
      overflow           <= write_valid && full;
    end
  end

  assign memory_write_enable  = transfer;
  assign memory_write_address = write_pointer[ADDRESS_WIDTH-1:0];
  assign memory_write_data    = write_data;

endmodule

// File: tb/tb_asynchronous_fifo_write_controller.sv
// Directed self-checking bench for the asynchronous FIFO write controller.
module tb_asynchronous_fifo_write_controller;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          write_clock = 1'b0;
  logic          write_resetn = 1'b0;
  logic          write_valid = 1'b0;
  logic [7:0]    write_data = '0;
  logic          write_ready;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          memory_write_enable;
  logic [AW-1:0] memory_write_address;
  logic [7:0]    memory_write_data;
  logic [AW:0]   write_pointer_gray;
  logic [AW:0]   read_pointer_gray = '0;

  int checks = 0;
  int failures = 0;

  asynchronous_fifo_write_controller #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .STAGES(2)
  ) dut (
    .write_clock          (write_clock),
    .write_resetn         (write_resetn),
    .write_valid          (write_valid),
    .write_data           (write_data),
    .write_ready          (write_ready),
    .full                 (full),
    .level                (level),
    .overflow             (overflow),
    .memory_write_enable  (memory_write_enable),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .write_pointer_gray   (write_pointer_gray),
    .read_pointer_gray    (read_pointer_gray)
  );

  always #5 write_clock = ~write_clock;

  function automatic logic [AW:0] gray(input int value);
    logic [AW:0] b;
    b = value[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge write_clock);
    #1;
  endtask

  task automatic test_reset();
    write_resetn = 1'b0;
    write_valid = 1'b1;
    write_data = 8'hAA;
    read_pointer_gray = '0;
    repeat (2) tick();
    checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", write_ready); end
    checks++; if (memory_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", memory_write_enable); end
    checks++; if ({full, overflow, level, memory_write_address, write_pointer_gray} !== '0) begin
      failures++; $display("FAIL reset_outputs: full=%b ovf=%b level=%0d addr=%0d wpg=%b want all 0",
                           full, overflow, level, memory_write_address, write_pointer_gray);
    end
    write_valid = 1'b0;
    write_resetn = 1'b1;
    #1;
    checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b want 1", write_ready); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL release_level: got %0d want 0", level); end
    tick();
  endtask

  task automatic test_fill();
    read_pointer_gray = '0;
    for (int i = 0; i < 16; i++) begin
      write_valid = 1'b1;
      write_data = 8'(8'h10 + i);
      #1;
      checks++; if (memory_write_enable !== 1'b1 || memory_write_address !== AW'(i) || memory_write_data !== 8'(8'h10 + i)) begin
        failures++; $display("FAIL fill_write[%0d]: we=%b addr=%0d data=%h want 1 %0d %h",
                             i, memory_write_enable, memory_write_address, memory_write_data, i, 8'h10 + i);
      end
      checks++; if (level !== 5'(i) || write_ready !== 1'b1) begin
        failures++; $display("FAIL fill_level[%0d]: level=%0d ready=%b want %0d 1", i, level, write_ready, i);
      end
      tick();
    end
    write_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1 || level !== 5'd16 || write_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full: full=%b level=%0d ready=%b want 1 16 0", full, level, write_ready);
    end
    checks++; if (write_pointer_gray !== gray(16)) begin
      failures++; $display("FAIL fill_gray: got %b want %b", write_pointer_gray, gray(16));
    end
  endtask

  task automatic test_overflow();
    write_valid = 1'b1;
    write_data = 8'hEE;
    #1;
    checks++; if (memory_write_enable !== 1'b0) begin failures++; $display("FAIL ovf_no_write: got %b want 0", memory_write_enable); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", overflow); end
    tick();
    write_valid = 1'b0;
    #1;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    checks++; if (memory_write_address !== 4'd0 || write_pointer_gray !== gray(16) || level !== 5'd16) begin
      failures++; $display("FAIL ovf_pointer: addr=%0d wpg=%b level=%0d want 0 %b 16",
                           memory_write_address, write_pointer_gray, level, gray(16));
    end
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
  endtask

  task automatic test_drain_visibility();
    read_pointer_gray = 5'b00110;
    tick();
    checks++; if (full !== 1'b1 || level !== 5'd16) begin
      failures++; $display("FAIL drain_early: full=%b level=%0d want 1 16", full, level);
    end
    tick();
    checks++; if (full !== 1'b0 || level !== 5'd12 || write_ready !== 1'b1) begin
      failures++; $display("FAIL drain_seen: full=%b level=%0d ready=%b want 0 12 1", full, level, write_ready);
    end
  endtask

  task automatic pulse_reset();
    write_valid = 1'b0;
    write_resetn = 1'b0;
    read_pointer_gray = '0;
    tick();
    write_resetn = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [AW:0] previous;
    for (int count = 0; count < 40; count++) begin
      write_valid = 1'b1;
      write_data = 8'(count);
      read_pointer_gray = gray(count >= 2 ? count - 2 : 0);
      #1;
      checks++; if (memory_write_enable !== 1'b1 || memory_write_address !== AW'(count % 16) || write_ready !== 1'b1) begin
        failures++; $display("FAIL wrap_addr[%0d]: we=%b addr=%0d ready=%b want 1 %0d 1",
                             count, memory_write_enable, memory_write_address, write_ready, count % 16);
      end
      previous = write_pointer_gray;
      tick();
      checks++; if (write_pointer_gray !== gray((count + 1) % 32) || $countones(write_pointer_gray ^ previous) != 1) begin
        failures++; $display("FAIL wrap_gray[%0d]: got %b prev %b want %b",
                             count, write_pointer_gray, previous, gray((count + 1) % 32));
      end
    end
    write_valid = 1'b0;
    read_pointer_gray = gray(38);
    repeat (2) tick();
    checks++; if (level !== 5'd2 || full !== 1'b0) begin
      failures++; $display("FAIL wrap_level: level=%0d full=%b want 2 0", level, full);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      write_valid = 1'b1;
      write_data = 8'(8'h50 + i);
      tick();
    end
    #2;
    write_resetn = 1'b0;
    read_pointer_gray = '0;
    #1;
    checks++; if (write_ready !== 1'b0 || memory_write_enable !== 1'b0) begin
      failures++; $display("FAIL midreset_stop: ready=%b we=%b want 0 0", write_ready, memory_write_enable);
    end
    checks++; if ({full, overflow, level, memory_write_address, write_pointer_gray} !== '0) begin
      failures++; $display("FAIL midreset_clear: full=%b ovf=%b level=%0d addr=%0d wpg=%b want all 0",
                           full, overflow, level, memory_write_address, write_pointer_gray);
    end
    repeat (2) tick();
    checks++; if (memory_write_enable !== 1'b0 || memory_write_address !== 4'd0) begin
      failures++; $display("FAIL midreset_hold: we=%b addr=%0d want 0 0", memory_write_enable, memory_write_address);
    end
    write_resetn = 1'b1;
    write_data = 8'h77;
    #1;
    checks++; if (memory_write_enable !== 1'b1 || memory_write_address !== 4'd0 || memory_write_data !== 8'h77) begin
      failures++; $display("FAIL midreset_first: we=%b addr=%0d data=%h want 1 0 77",
                           memory_write_enable, memory_write_address, memory_write_data);
    end
    tick();
    write_valid = 1'b0;
    #1;
    checks++; if (level !== 5'd1 || write_pointer_gray !== gray(1) || memory_write_address !== 4'd1) begin
      failures++; $display("FAIL midreset_after: level=%0d wpg=%b addr=%0d want 1 %b 1",
                           level, write_pointer_gray, memory_write_address, gray(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_visibility();
    pulse_reset();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/asynchronous_fifo_write_controller.md
# asynchronous_fifo_write_controller

Write-side controller of an asynchronous FIFO built around the dual-clock RAM. Accepts a valid/ready write stream in the `write_clock` domain and drives the RAM write port (enable, address, data). Publishes a Gray-coded write pointer to the read domain, synchronizes the Gray read pointer coming back, and derives full, level and overflow. The read-side controller is a separate block; this block contains no read-domain logic.

## Interface

- `WIDTH`, 8: data width in bits.
- `DEPTH`, 16: FIFO depth in entries; power of two, ≥ 2.
- `ADDRESS_WIDTH`, `CLOG2(DEPTH)`: RAM address width.
- `STAGES`, 2: synchronizer flop count for the incoming read pointer; ≥ 2.

Ports:

- `write_clock`  in  1  write-domain clock.
- `write_resetn`  in  1  reset, asynchronous, active-low.
- `write_valid`  in  1  producer has data.
- `write_data`  in  WIDTH  producer data.
- `write_ready`  out  1  space available; a transfer occurs when `write_valid` && `write_ready`.
- `full`  out  1  FIFO full, as seen from the write domain.
- `level`  out  ADDRESS_WIDTH+1  occupancy, 0..DEPTH, as seen from the write domain.
- `overflow`  out  1  one-cycle registered pulse after a write attempted while full.
- `memory_write_enable`  out  1  RAM write enable.
- `memory_write_address`  out  ADDRESS_WIDTH  RAM write address.
- `memory_write_data`  out  WIDTH  RAM write data.
- `write_pointer_gray`  out  ADDRESS_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `read_pointer_gray`  in  ADDRESS_WIDTH+1  Gray read pointer from the read domain; asynchronous to `write_clock`.

## Operation

- Internal binary write pointer `wp`, ADDRESS_WIDTH+1 bits, is the registered source of truth.
- `write_pointer_gray` is a register loaded with gray(`wp` next) on the same edge that `wp` updates. It is never derived combinationally at the output.
- Transfer = `write_valid` && `write_ready`. On a transfer, `wp` increments modulo 2^(ADDRESS_WIDTH+1).
- `memory_write_enable` = transfer (combinational). `memory_write_address` = `wp`[ADDRESS_WIDTH-1:0]. `memory_write_data` = `write_data`.
- `read_pointer_gray` passes through STAGES flops to give `rp_sync_gray`, which is converted to binary `rp_sync`.
- `level` = (`wp` − `rp_sync`) mod 2^(ADDRESS_WIDTH+1).
- `full` = (`level` == DEPTH). This is equivalent to the Gray compare where the top two bits are inverted and the rest are equal.
- `write_ready` = !`full`, and is forced to 0 while `write_resetn` is low.
- Write while full: no RAM write, `wp` unchanged, and `overflow` pulses high on the next cycle. The producer must hold its data.
- Every output is combinational from registers, except `memory_write_enable`, `memory_write_data` and `write_ready`, which also depend on inputs.

## Timing

- Reset values: `wp` = 0, `write_pointer_gray` = 0, all synchronizer flops = 0, `overflow` = 0, `full` = 0, `level` = 0, `memory_write_enable` = 0, `write_ready` = 0.
- Write latency: the RAM captures data on the same `write_clock` edge as the transfer, with zero added cycles.
- `full` and `level` reflect a transfer in the cycle after its edge.
- Read-side progress is visible after STAGES `write_clock` edges. The view is pessimistic: `full` may stay high longer than necessary but is never deasserted early. `level` is never under-reported.
- Wrap-around: `memory_write_address` wraps from DEPTH−1 to 0. `wp` wraps from 2^(ADDRESS_WIDTH+1)−1 to 0. Consecutive `write_pointer_gray` values differ by exactly one bit.
- A transfer on the same edge that the synchronized read pointer advances is allowed: `level` reflects both events.
- Reset mid-operation: all state clears asynchronously and no write is issued during reset. The read domain must be reset together with this block; resetting only one side is unsupported.

## Structure

- Shared include alongside `clog2.vh`: Gray/binary conversion functions (`BINARY_TO_GRAY`, `GRAY_TO_BINARY`), parameterized by width, for reuse by the read-side controller.
- One sub-module: `vector_synchronizer` (WIDTH, STAGES; clock, resetn, async input, synced output), instantiated once for `read_pointer_gray`. The read controller reuses it for the write pointer.

## Test plan

- Reset: hold `write_resetn` low while driving `write_valid` = 1. Required: `write_ready` = 0, `memory_write_enable` = 0, all outputs 0; after release, `write_ready` = 1 and `level` = 0.
- Fill: `read_pointer_gray` = 0, then 16 back-to-back writes of 0x10..0x1F. Required: addresses 0..15 and data matching; after the 16th write, `full` = 1, `level` = 16, `write_ready` = 0.
- Overflow: while full, `write_valid` = 1 for 1 cycle. Required: no `memory_write_enable`, `wp` unchanged, `overflow` high for exactly 1 cycle.
- Drain visibility: from full, set `read_pointer_gray` = gray(4) = 0b00110. Required: `full` deasserts and `level` = 12 exactly STAGES edges later, not earlier.
- Wrap: 40 writes, with `read_pointer_gray` tracking `wp` − 2 to avoid full. Required: address sequence 0..15, 0..15, 0..7; `write_pointer_gray` changes one bit per transfer; wrap at pointer 31 → 0 is seamless.
- Mid-operation reset: assert `write_resetn` after 5 writes. Required: immediate return to the reset values above; the next write after release goes to address 0.
